// File: rtl/mem_access_stage.sv
// MEM stage of the pipelined RISC-V core: drives the req/ack data-memory bus
// from the EX/MEM bundle, stalls upstream while an access is in flight, formats
// load data and registers the MEM/WB bundle for writeback.
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       EX_MEM_alu_result,
  input  logic [31:0]       EX_MEM_read2_data,
  input  logic [4:0]        EX_MEM_RD,
  input  logic              EX_MEM_RegWrite,
  input  logic [2:0]        EX_MEM_WDSel,
  input  logic              EX_MEM_MemWrite,
  input  logic              EX_MEM_MemRead,
  input  logic [2:0]        EX_MEM_DMType,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic              misalign_exc,
  output logic [31:0]       MEM_WB_alu_result,
  output logic [31:0]       MEM_WB_load_data,
  output logic [4:0]        MEM_WB_RD,
  output logic              MEM_WB_RegWrite,
  output logic [2:0]        MEM_WB_WDSel
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [31:0] load_data_p0;

  logic       is_access;
  logic       is_store;
  logic       is_half;
  logic       is_byte;
  logic       misaligned;
  logic       in_req;
  logic [1:0] off;

  // Byte enables for a store: lane mask shifted to the addressed offset.
  function automatic logic [3:0] store_be(input logic half, input logic byte_acc,
                                          input logic [1:0] ofs);
    if (byte_acc)  return 4'b0001 << ofs;
    else if (half) return 4'b0011 << ofs;
    else           return 4'b1111;
  endfunction

  // Store data replicated across every lane so any offset sees its bytes.
  function automatic logic [31:0] store_wdata(input logic half, input logic byte_acc,
                                              input logic [31:0] data);
    if (byte_acc)  return {4{data[7:0]}};
    else if (half) return {2{data[15:0]}};
    else           return data;
  endfunction

  // Lane select plus sign/zero extension of the returned read word.
  function automatic logic [31:0] load_format(input logic [2:0] dmtype, input logic [1:0] ofs,
                                              input logic [31:0] rdata);
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;
    lane_b = rdata[{ofs, 3'b000} +: 8];
    lane_h = rdata[{ofs[1], 4'b0000} +: 16];
    case (dmtype)
      3'b001:  return {{16{lane_h[15]}}, lane_h};
      3'b010:  return {16'h0000, lane_h};
      3'b011:  return {{24{lane_b[7]}}, lane_b};
      3'b100:  return {24'h000000, lane_b};
      default: return rdata;
    endcase
  endfunction

  assign off        = EX_MEM_alu_result[1:0];
  assign is_access  = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign is_store   = EX_MEM_MemWrite;
  assign is_half    = (EX_MEM_DMType == 3'b001) || (EX_MEM_DMType == 3'b010);
  assign is_byte    = (EX_MEM_DMType == 3'b011) || (EX_MEM_DMType == 3'b100);
  // Unknown access types behave as words, so they need full alignment.
  assign misaligned = is_access & ((is_half & off[0]) | (~is_half & ~is_byte & (off != 2'b00)));

  // Bus outputs exist only in REQ; the frozen EX/MEM inputs keep them stable until ack.
  assign in_req     = (state == REQ);
  assign dmem_req   = in_req;
  assign dmem_we    = in_req & is_store;
  assign dmem_addr  = in_req ? {EX_MEM_alu_result[ADDR_W-1:2], 2'b00} : '0;
  assign dmem_be    = (in_req && is_store) ? store_be(is_half, is_byte, off) : 4'b0000;
  assign dmem_wdata = (in_req && is_store) ? store_wdata(is_half, is_byte, EX_MEM_read2_data) : 32'h0;

  // Upstream freeze: from the first aligned-access cycle until ack; forced low during reset.
  always_comb begin
    mem_stall = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    mem_stall = is_access & ~misaligned;
        REQ:     mem_stall = 1'b1;
        default: mem_stall = 1'b0;
      endcase
    end
  end

  // Access FSM and MEM/WB register; REQ and the access cycle in IDLE insert bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      misalign_exc      <= 1'b0;
      load_data_p0      <= 32'h0;
      MEM_WB_alu_result <= 32'h0;
      MEM_WB_load_data  <= 32'h0;
      MEM_WB_RD         <= 5'd0;
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_WDSel      <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          MEM_WB_alu_result <= EX_MEM_alu_result;
          MEM_WB_RD         <= EX_MEM_RD;
          MEM_WB_WDSel      <= EX_MEM_WDSel;
          MEM_WB_load_data  <= 32'h0;
          MEM_WB_RegWrite   <= EX_MEM_RegWrite & ~is_access;
          misalign_exc      <= misaligned;
          if (is_access && !misaligned) state <= REQ;
        end
        REQ: begin
          MEM_WB_RegWrite <= 1'b0;
          misalign_exc    <= 1'b0;
          if (dmem_ack) begin
            load_data_p0 <= is_store ? 32'h0 : load_format(EX_MEM_DMType, off, dmem_rdata);
            state        <= DONE;
          end
        end
        DONE: begin
          MEM_WB_alu_result <= EX_MEM_alu_result;
          MEM_WB_RD         <= EX_MEM_RD;
          MEM_WB_WDSel      <= EX_MEM_WDSel;
          MEM_WB_RegWrite   <= EX_MEM_RegWrite;
          MEM_WB_load_data  <= load_data_p0;
          misalign_exc      <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// accesses checked against a transaction-level model of the MEM stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] EX_MEM_alu_result = '0;
  logic [31:0] EX_MEM_read2_data = '0;
  logic [4:0]  EX_MEM_RD = '0;
  logic        EX_MEM_RegWrite = 1'b0;
  logic [2:0]  EX_MEM_WDSel = '0;
  logic        EX_MEM_MemWrite = 1'b0;
  logic        EX_MEM_MemRead = 1'b0;
  logic [2:0]  EX_MEM_DMType = '0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        mem_stall;
  logic        misalign_exc;
  logic [31:0] MEM_WB_alu_result;
  logic [31:0] MEM_WB_load_data;
  logic [4:0]  MEM_WB_RD;
  logic        MEM_WB_RegWrite;
  logic [2:0]  MEM_WB_WDSel;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .EX_MEM_alu_result(EX_MEM_alu_result), .EX_MEM_read2_data(EX_MEM_read2_data),
    .EX_MEM_RD(EX_MEM_RD), .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_WDSel(EX_MEM_WDSel),
    .EX_MEM_MemWrite(EX_MEM_MemWrite), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_DMType(EX_MEM_DMType),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .misalign_exc(misalign_exc),
    .MEM_WB_alu_result(MEM_WB_alu_result), .MEM_WB_load_data(MEM_WB_load_data),
    .MEM_WB_RD(MEM_WB_RD), .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_WDSel(MEM_WB_WDSel)
  );

  always #5 clk = ~clk;

  task automatic set_nop();
    EX_MEM_alu_result = 32'h0;
    EX_MEM_read2_data = 32'h0;
    EX_MEM_RD         = 5'd0;
    EX_MEM_RegWrite   = 1'b0;
    EX_MEM_WDSel      = 3'd0;
    EX_MEM_MemRead    = 1'b0;
    EX_MEM_MemWrite   = 1'b0;
    EX_MEM_DMType     = 3'd0;
  endtask

  // One instruction through MEM, with the memory answering after `waits` wait cycles.
  task automatic do_access(input logic mr, input logic mw, input logic [2:0] t,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [4:0] rd, input logic rw, input logic [2:0] wds,
                           input int waits, input logic [31:0] rdata);
    int size, ofs, b, stalls;
    bit acc, mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_load;

    // Reference model: access size, alignment, lanes and the loaded value.
    size = (t == 3'd1 || t == 3'd2) ? 2 : (t == 3'd3 || t == 3'd4) ? 1 : 4;
    ofs  = int'(addr % 4);
    acc  = mr || mw;
    mis  = acc && ((addr % size) != 0);
    exp_be    = mw ? 4'(((1 << size) - 1) << ofs) : 4'd0;
    exp_wdata = !mw ? 32'h0 : (size == 1) ? (data & 32'hFF) * 32'h0101_0101 :
                (size == 2) ? (data & 32'hFFFF) * 32'h0001_0001 : data;
    if (mw) exp_load = 32'h0;
    else if (size == 4) exp_load = rdata;
    else begin
      b = int'((rdata >> (8 * ofs)) & ((size == 1) ? 32'hFF : 32'hFFFF));
      if (size == 1 && t == 3'd3 && b >= 128) b = b - 256;
      if (size == 2 && t == 3'd1 && b >= 32768) b = b - 65536;
      exp_load = 32'(b);
    end

    @(posedge clk); #1;
    EX_MEM_alu_result = addr; EX_MEM_read2_data = data; EX_MEM_RD = rd;
    EX_MEM_RegWrite = rw; EX_MEM_WDSel = wds; EX_MEM_MemRead = mr;
    EX_MEM_MemWrite = mw; EX_MEM_DMType = t; dmem_ack = 1'b0;

    @(negedge clk);
    checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b, expected 0", dmem_req); end
    checks++; if (mem_stall !== (acc && !mis)) begin errors++; $display("FAIL idle_stall: got %b, expected %b", mem_stall, acc && !mis); end

    if (!acc || mis) begin
      @(posedge clk); #1;
      checks++; if (misalign_exc !== mis) begin errors++; $display("FAIL misalign_exc: got %b, expected %b", misalign_exc, mis); end
      checks++; if (MEM_WB_RegWrite !== (rw && !acc)) begin errors++; $display("FAIL wb_regwrite_direct: got %b, expected %b", MEM_WB_RegWrite, rw && !acc); end
      checks++; if (MEM_WB_alu_result !== addr) begin errors++; $display("FAIL wb_alu_direct: got %h, expected %h", MEM_WB_alu_result, addr); end
      checks++; if (MEM_WB_RD !== rd || MEM_WB_WDSel !== wds) begin errors++; $display("FAIL wb_rd_wdsel_direct: got %0d/%0d, expected %0d/%0d", MEM_WB_RD, MEM_WB_WDSel, rd, wds); end
      checks++; if (MEM_WB_load_data !== 32'h0) begin errors++; $display("FAIL wb_load_direct: got %h, expected 0", MEM_WB_load_data); end
      set_nop();
      @(posedge clk); #1;
      checks++; if (misalign_exc !== 1'b0) begin errors++; $display("FAIL misalign_pulse_end: got %b, expected 0", misalign_exc); end
      return;
    end

    stalls = 1;
    @(posedge clk); #1;
    for (int w = 0; w <= waits; w++) begin
      dmem_ack   = (w == waits);
      dmem_rdata = (w == waits) ? rdata : $urandom;
      @(negedge clk);
      if (mem_stall === 1'b1) stalls++;
      checks++; if (dmem_req !== 1'b1 || dmem_we !== mw) begin errors++; $display("FAIL req_we: got %b/%b, expected 1/%b", dmem_req, dmem_we, mw); end
      checks++; if (dmem_addr !== {addr[31:2], 2'b00}) begin errors++; $display("FAIL req_addr: got %h, expected %h", dmem_addr, {addr[31:2], 2'b00}); end
      checks++; if (dmem_be !== exp_be) begin errors++; $display("FAIL req_be: got %b, expected %b", dmem_be, exp_be); end
      if (mw) begin
        checks++; if (dmem_wdata !== exp_wdata) begin errors++; $display("FAIL req_wdata: got %h, expected %h", dmem_wdata, exp_wdata); end
      end
      checks++; if (MEM_WB_RegWrite !== 1'b0 || misalign_exc !== 1'b0) begin errors++; $display("FAIL req_bubble: got %b/%b, expected 0/0", MEM_WB_RegWrite, misalign_exc); end
      @(posedge clk); #1;
    end
    dmem_ack = 1'b0;

    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL done_req_stall: got %b/%b, expected 0/0", dmem_req, mem_stall); end
    checks++; if (stalls !== waits + 2) begin errors++; $display("FAIL stall_cycles: got %0d, expected %0d", stalls, waits + 2); end
    @(posedge clk); #1;
    checks++; if (MEM_WB_load_data !== exp_load) begin errors++; $display("FAIL wb_load: got %h, expected %h", MEM_WB_load_data, exp_load); end
    checks++; if (MEM_WB_alu_result !== addr || MEM_WB_RD !== rd) begin errors++; $display("FAIL wb_alu_rd: got %h/%0d, expected %h/%0d", MEM_WB_alu_result, MEM_WB_RD, addr, rd); end
    checks++; if (MEM_WB_RegWrite !== rw || MEM_WB_WDSel !== wds) begin errors++; $display("FAIL wb_rw_wdsel: got %b/%0d, expected %b/%0d", MEM_WB_RegWrite, MEM_WB_WDSel, rw, wds); end
    set_nop();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_nop();
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({dmem_req, mem_stall, misalign_exc, MEM_WB_RegWrite} !== 4'b0) begin errors++; $display("FAIL reset_ctrl: got %b, expected 0000", {dmem_req, mem_stall, misalign_exc, MEM_WB_RegWrite}); end
    checks++; if ({MEM_WB_alu_result, MEM_WB_load_data, MEM_WB_RD, MEM_WB_WDSel} !== 72'h0) begin errors++; $display("FAIL reset_wb: got %h, expected 0", {MEM_WB_alu_result, MEM_WB_load_data, MEM_WB_RD, MEM_WB_WDSel}); end
    rst = 1'b0;
  endtask

  task automatic test_alu_op();
    do_access(1'b0, 1'b0, 3'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 3'd2, 0, 32'h0);
  endtask

  task automatic test_load_byte();
    do_access(1'b1, 1'b0, 3'b011, 32'h103, 32'h0, 5'd9, 1'b1, 3'd1, 0, 32'h80FF_0000);
  endtask

  task automatic test_store_half();
    do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'hABCD_1234, 5'd0, 1'b0, 3'd0, 3, 32'h0);
  endtask

  task automatic test_misalign();
    do_access(1'b1, 1'b0, 3'b000, 32'h006, 32'h0, 5'd3, 1'b1, 3'd1, 0, 32'h0);
    do_access(1'b0, 1'b1, 3'b010, 32'h011, 32'h5555, 5'd0, 1'b0, 3'd0, 0, 32'h0);
  endtask

  task automatic test_load_half_unsigned();
    do_access(1'b1, 1'b0, 3'b010, 32'h012, 32'h0, 5'd11, 1'b1, 3'd1, 1, 32'h9ABC_0000);
  endtask

  task automatic test_reset_mid_access();
    logic [112:0] all_out;
    @(posedge clk); #1;
    EX_MEM_alu_result = 32'h40; EX_MEM_RD = 5'd7; EX_MEM_RegWrite = 1'b1;
    EX_MEM_MemRead = 1'b1; EX_MEM_DMType = 3'd0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: got %b, expected 1", dmem_req); end
    #2 rst = 1'b1;
    #1;
    all_out = {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be, mem_stall, misalign_exc,
               MEM_WB_alu_result, MEM_WB_RD, MEM_WB_RegWrite, MEM_WB_WDSel};
    checks++; if (all_out !== '0) begin errors++; $display("FAIL async_reset_outputs: got %h, expected 0", all_out); end
    checks++; if (MEM_WB_load_data !== 32'h0) begin errors++; $display("FAIL async_reset_load: got %h, expected 0", MEM_WB_load_data); end
    set_nop();
    @(posedge clk); #1;
    rst = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin errors++; $display("FAIL late_ack_req: got %b/%b, expected 0/0", dmem_req, mem_stall); end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b0 || MEM_WB_load_data !== 32'h0) begin errors++; $display("FAIL late_ack_idle: got %b/%h, expected 0/0", dmem_req, MEM_WB_load_data); end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    for (int i = 0; i < 40; i++) begin
      addr = $urandom;
      if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
      do_access(1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), addr, $urandom,
                5'($urandom), 1'($urandom), 3'($urandom), int'($urandom_range(0, 3)), $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_load_half_unsigned();
    test_reset_mid_access();
    test_load_half_unsigned();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer side of the EX/MEM pipeline register; the MEM stage of the pipelined RISC-V core.
- Takes the EX/MEM bundle and performs loads and stores over a req/ack data-memory bus.
- Stalls the upstream pipeline while an access is in flight.
- Formats load data (byte/half/word, signed/unsigned) and registers the MEM/WB bundle for writeback.

Parameters:
- ADDR_W, 32, data-memory address width (lower ADDR_W bits of EX_MEM_alu_result are used).

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- EX_MEM_alu_result  in  32  effective address, or ALU result for non-memory instructions
- EX_MEM_read2_data  in  32  store data
- EX_MEM_RD  in  5  destination register
- EX_MEM_RegWrite  in  1  register write enable
- EX_MEM_WDSel  in  3  writeback select, passed through
- EX_MEM_MemWrite  in  1  store
- EX_MEM_MemRead  in  1  load
- EX_MEM_DMType  in  3  access type: 000=word, 001=half signed, 010=half unsigned, 011=byte signed, 100=byte unsigned; others are treated as word
- dmem_req  out  1  bus request
- dmem_we  out  1  write strobe
- dmem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ack  in  1  access complete; rdata is valid in the same cycle
- dmem_rdata  in  32  read word
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM (combinational)
- misalign_exc  out  1  one-cycle registered pulse on a misaligned access
- MEM_WB_alu_result  out  32
- MEM_WB_load_data  out  32
- MEM_WB_RD  out  5
- MEM_WB_RegWrite  out  1
- MEM_WB_WDSel  out  3

Behaviour:
- Reset: state=IDLE; all registered outputs are 0; dmem_req drops immediately (asynchronous).
- Reset mid-access abandons the access. A late dmem_ack after reset is ignored in IDLE.
- An access exists when MemRead|MemWrite. MemRead and MemWrite together count as a store.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.

FSM states: IDLE, REQ, DONE.
- IDLE, no access:
  - mem_stall=0.
  - At the edge: MEM_WB_* load the EX_MEM values; MEM_WB_load_data<=0.
  - Latency 1 cycle.
- IDLE, misaligned access:
  - No bus request; mem_stall=0.
  - At the edge: misalign_exc<=1 and MEM_WB_RegWrite<=0.
- IDLE, aligned access:
  - mem_stall=1; next state REQ.
  - MEM_WB_RegWrite<=0 (bubble).
- REQ:
  - dmem_req=1; dmem_we=MemWrite.
  - addr, wdata and be are driven from the frozen EX/MEM inputs and stay stable until ack.
  - mem_stall=1; MEM_WB_RegWrite<=0 every cycle.
  - On dmem_ack: capture the formatted rdata into an internal load register; next state DONE.
  - Otherwise remain in REQ. There is no timeout.
- DONE:
  - dmem_req=0; mem_stall=0.
  - At the edge: MEM_WB_* load the EX_MEM values and MEM_WB_load_data<=load register (0 for stores); next state IDLE.
- Minimum access latency is 3 cycles (IDLE, REQ with same-cycle ack, DONE). Each wait cycle adds 1.
- misalign_exc is 0 in every cycle other than the one following a misaligned detect.

Store formatting (off=addr[1:0]):
- Byte: be=4'b0001<<off; wdata={4{data[7:0]}}.
- Half: be=4'b0011<<off; wdata={2{data[15:0]}}.
- Word: be=4'b1111; wdata=data.
- dmem_be=0 on loads.

Load formatting:
- Select byte rdata[8*off+:8] or half rdata[16*off[1]+:16].
- Signed types sign-extend to 32 bits; unsigned types zero-extend.

Test Plan:
- Reset, then a non-memory op (alu_result=0x1234, RD=5, RegWrite=1) -> next cycle MEM_WB_alu_result=0x1234, RD=5, RegWrite=1; mem_stall never asserts.
- lb signed at addr 0x103, dmem_rdata=0x80FF_0000, ack in the first REQ cycle -> stall is high for exactly 2 cycles; dmem_addr=0x100; MEM_WB_load_data=0xFFFF_FF80 one cycle after DONE.
- sh at addr 0x202, data 0xABCD_1234, ack after 3 wait cycles -> dmem_we=1, be=4'b1100, wdata=0x1234_1234, all held stable for 4 REQ cycles; MEM_WB_RegWrite=0 throughout.
- lw at addr 0x006 -> no dmem_req; misalign_exc pulses for exactly 1 cycle; MEM_WB_RegWrite=0; no stall.
- rst asserted while in REQ with no ack -> dmem_req drops and all outputs are 0 without waiting for a clock edge. Ack pulsed after rst releases -> state remains IDLE.
- lhu at addr 0x012, rdata=0x9ABC_0000 -> MEM_WB_load_data=0x0000_9ABC.
